// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one read at a time to instruction
// memory and presents the decoded word to the IF/ID latch under its stall/flush.
`timescale 1ns/1ps
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] PC_4_IF,
  output logic [5:0]  op_IF,
  output logic [4:0]  Rs_IF,
  output logic [4:0]  Rt_IF,
  output logic [4:0]  Rd_IF,
  output logic [4:0]  Shamt_IF,
  output logic [5:0]  Func_IF
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_FULL
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt, pc_inc;
  logic            kill, kill_nxt;
  logic [XLEN-1:0] hold_word, hold_nxt;
  logic [XLEN-1:0] word, word_nxt;
  logic [XLEN-1:0] pc4, pc4_nxt;
  logic            valid, valid_nxt;
  logic            req_nxt;
  logic [XLEN-1:0] addr_nxt;
  logic            consume;
  logic [XLEN-1:0] redirect_aligned;

  assign pc_inc           = pc + XLEN'(4);
  assign consume          = valid & ~stall;
  assign redirect_aligned = redirect_pc & ~XLEN'(3);

  // Next-state, slot and PC update; redirect is applied last so it overrides all.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    kill_nxt  = kill;
    hold_nxt  = hold_word;
    word_nxt  = word;
    pc4_nxt   = pc4;
    valid_nxt = valid;
    req_nxt   = 1'b0;
    addr_nxt  = imem_addr;

    if (consume) begin
      valid_nxt = 1'b0;
      word_nxt  = '0;
      pc4_nxt   = '0;
    end

    case (state)
      ST_IDLE: state_nxt = ST_REQ;
      ST_REQ:  state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (kill) begin
            kill_nxt  = 1'b0;
            state_nxt = ST_REQ;
          end else if (!valid || consume) begin
            word_nxt  = imem_rdata;
            pc4_nxt   = pc_inc;
            valid_nxt = 1'b1;
            pc_nxt    = pc_inc;
            state_nxt = ST_REQ;
          end else begin
            hold_nxt  = imem_rdata;
            state_nxt = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        if (consume) begin
          word_nxt  = hold_word;
          pc4_nxt   = pc_inc;
          valid_nxt = 1'b1;
          pc_nxt    = pc_inc;
          state_nxt = ST_REQ;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (redirect) begin
      pc_nxt    = redirect_aligned;
      word_nxt  = '0;
      pc4_nxt   = '0;
      valid_nxt = 1'b0;
      hold_nxt  = '0;
      kill_nxt  = 1'b0;
      case (state)
        ST_WAIT: begin
          if (imem_rvalid) begin
            state_nxt = ST_REQ;
          end else begin
            kill_nxt  = 1'b1;
            state_nxt = ST_WAIT;
          end
        end
        // The strobe of this REQ cycle is already out, so its answer must be dropped.
        ST_REQ: begin
          kill_nxt  = 1'b1;
          state_nxt = ST_WAIT;
        end
        default: state_nxt = ST_REQ;
      endcase
    end

    req_nxt = (state_nxt == ST_REQ);
    if (req_nxt) begin
      addr_nxt = pc_nxt;
    end
  end

  // State, PC, buffer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      kill      <= 1'b0;
      hold_word <= '0;
      word      <= '0;
      pc4       <= '0;
      valid     <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      kill      <= kill_nxt;
      hold_word <= hold_nxt;
      word      <= word_nxt;
      pc4       <= pc4_nxt;
      valid     <= valid_nxt;
      imem_req  <= req_nxt;
      imem_addr <= addr_nxt;
    end
  end

  assign inst_valid = valid;
  assign PC_4_IF    = pc4;
  assign op_IF      = word[31:26];
  assign Rs_IF      = word[25:21];
  assign Rt_IF      = word[20:16];
  assign Rd_IF      = word[15:11];
  assign Shamt_IF   = word[10:6];
  assign Func_IF    = word[5:0];

endmodule
